// File: rtl/can_rx_destuff.sv
// rtl/can_rx_destuff.sv - CAN receive bit destuffer with CRC-15 accumulator
module can_rx_destuff #(
    parameter int          STUFF_LEN = 5,
    parameter logic [14:0] CRC_POLY  = 15'h4599
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample,
    input  logic        rx_bit,
    input  logic        clear,
    input  logic        destuff_en,
    input  logic        crc_en,
    output logic        shift_en,
    output logic        shift_bit,
    output logic        stuff_pulse,
    output logic        stuff_err,
    output logic [14:0] crc,
    output logic        crc_zero,
    output logic [6:0]  bit_cnt
);

    localparam logic [2:0] RUN_MAX = 3'(STUFF_LEN);

    logic [2:0]  run_cnt;
    logic        last_bit;
    logic        accept;
    logic        at_limit;
    logic        is_stuff;
    logic        is_err;
    logic        do_fwd;
    logic        new_run;
    logic        crc_nxt;
    logic [14:0] crc_upd;

    // A full run with destuffing on means the next bit is never data:
    // it is either the stuff bit or a stuff violation.
    always_comb begin
        accept   = sample && !stuff_err;
        at_limit = destuff_en && (run_cnt == RUN_MAX);
        is_stuff = accept && at_limit && (rx_bit != last_bit);
        is_err   = accept && at_limit && (rx_bit == last_bit);
        do_fwd   = accept && !at_limit;
        new_run  = (run_cnt == 3'd0) || (rx_bit != last_bit);
        crc_nxt  = rx_bit ^ crc[14];
        crc_upd  = {crc[13:0], 1'b0} ^ (crc_nxt ? CRC_POLY : 15'd0);
    end

    assign crc_zero = (crc == 15'd0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_en    <= 1'b0;
            shift_bit   <= 1'b0;
            stuff_pulse <= 1'b0;
            stuff_err   <= 1'b0;
            crc         <= 15'd0;
            bit_cnt     <= 7'd0;
            run_cnt     <= 3'd0;
            last_bit    <= 1'b1;
        end else if (clear) begin
            shift_en    <= 1'b0;
            stuff_pulse <= 1'b0;
            stuff_err   <= 1'b0;
            crc         <= 15'd0;
            bit_cnt     <= 7'd0;
            run_cnt     <= 3'd0;
            last_bit    <= 1'b1;
        end else begin
            shift_en    <= do_fwd;
            stuff_pulse <= is_stuff;
            if (is_err) begin
                stuff_err <= 1'b1;
            end
            // The removed stuff bit opens the next run of identical bits.
            if (is_stuff) begin
                run_cnt  <= 3'd1;
                last_bit <= rx_bit;
            end
            if (do_fwd) begin
                shift_bit <= rx_bit;
                last_bit  <= rx_bit;
                if (bit_cnt != 7'd127) begin
                    bit_cnt <= bit_cnt + 7'd1;
                end
                if (crc_en) begin
                    crc <= crc_upd;
                end
                if (!destuff_en) begin
                    run_cnt <= 3'd0;
                end else if (new_run) begin
                    run_cnt <= 3'd1;
                end else begin
                    run_cnt <= run_cnt + 3'd1;
                end
            end
        end
    end

endmodule
